conv_encoder_stream: RTL and testbench

Streaming, parametrised convolutional encoder. It replaces the fixed-frame encoder with a valid/ready bit-in, symbol-out pipeline stage. Constraint length, code rate (1/2 or 1/3) and generator polynomials are chosen at run time up to compile-time maxima. Each frame is an optional zero-tail terminated block of programmable length, and the block feeds the channel/branch-metric path ahead of the Viterbi decoder.

---
 rtl/conv_encoder_stream.sv | 172 +++++++++++++++++
 tb/tb_conv_encoder_stream.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_stream.sv
// Streaming convolutional encoder: valid/ready bit in, symbol out.
// Run-time K, rate and polynomials; optional zero-tail termination.
module conv_encoder_stream #(
  parameter int K_MAX = 9,
  parameter int N_MAX = 3,
  parameter int LEN_W = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [LEN_W-1:0]            i_frame_len,
  input  logic [3:0]                  i_k,
  input  logic                        i_code_rate,
  input  logic                        i_tail_en,
  input  logic [N_MAX-1:0][K_MAX-1:0] i_gen_poly,
  input  logic                        i_valid,
  input  logic                        i_data,
  output logic                        o_ready,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [N_MAX-1:0]            o_sym,
  output logic                        o_last,
  output logic                        o_busy,
  output logic                        o_frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL,
    FLUSH
  } state_t;

  state_t state, state_nx;

  logic [LEN_W-1:0]            len_q;
  logic [LEN_W-1:0]            cnt;
  logic [3:0]                  k_q;
  logic                        rate_q;
  logic                        tail_q;
  logic [N_MAX-1:0][K_MAX-1:0] poly_q;
  logic [K_MAX-2:0]            sr;

  logic             slot;
  logic             accept;
  logic             load;
  logic             bit_in;
  logic             last_in;
  logic             cnt_clr;
  logic [3:0]       k_in;
  logic [K_MAX-1:0] win;
  logic [K_MAX-1:0] mask;
  logic [N_MAX-1:0] sym_nx;

  // Output slot is free when empty or being drained this cycle.
  assign slot    = !o_valid || i_ready;
  assign o_ready = (state == DATA) && slot;
  assign o_busy  = (state != IDLE);

  // Out-of-range constraint lengths fall back to the maximum.
  assign k_in = (i_k < 4'd3 || i_k > 4'(K_MAX)) ? 4'(K_MAX) : i_k;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state, bit injection and frame-done decode.
  always_comb begin
    state_nx     = state;
    accept       = 1'b0;
    load         = 1'b0;
    bit_in       = 1'b0;
    last_in      = 1'b0;
    cnt_clr      = 1'b0;
    o_frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          accept = 1'b1;
          if (i_frame_len != '0) state_nx = DATA;
          else if (i_tail_en)    state_nx = TAIL;
          else                   state_nx = FLUSH;
        end
      end
      DATA: begin
        if (i_valid && o_ready) begin
          load   = 1'b1;
          bit_in = i_data;
          if (cnt == len_q - LEN_W'(1)) begin
            cnt_clr = 1'b1;
            if (tail_q) begin
              state_nx = TAIL;
            end else begin
              state_nx = FLUSH;
              last_in  = 1'b1;
            end
          end
        end
      end
      TAIL: begin
        if (slot) begin
          load = 1'b1;
          if (cnt == LEN_W'(k_q) - LEN_W'(2)) begin
            cnt_clr  = 1'b1;
            last_in  = 1'b1;
            state_nx = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (!o_valid) begin
          o_frame_done = 1'b1;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Tap window, active-tap mask and next symbol.
  always_comb begin
    win    = {sr, bit_in};
    mask   = '0;
    sym_nx = '0;
    for (int j = 0; j < K_MAX; j++)
      mask[j] = (4'(j) < k_q);
    for (int i = 0; i < N_MAX; i++) begin
      sym_nx[i] = ^(win & mask & poly_q[i]);
      if (i >= 3 || (i == 2 && !rate_q))
        sym_nx[i] = 1'b0;
    end
  end

  // Config latch, shift register, counter and output symbol register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      k_q     <= '0;
      rate_q  <= 1'b0;
      tail_q  <= 1'b0;
      poly_q  <= '0;
      sr      <= '0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_sym   <= '0;
      o_last  <= 1'b0;
    end else begin
      if (accept) begin
        len_q  <= i_frame_len;
        k_q    <= k_in;
        rate_q <= i_code_rate;
        tail_q <= i_tail_en;
        poly_q <= i_gen_poly;
        sr     <= '0;
        cnt    <= '0;
      end
      if (load) begin
        sr      <= {sr[K_MAX-3:0], bit_in};
        cnt     <= cnt_clr ? '0 : cnt + LEN_W'(1);
        o_sym   <= sym_nx;
        o_valid <= 1'b1;
        o_last  <= last_in;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_encoder_stream.sv
// Testbench for conv_encoder_stream: fixed vectors, random frames
// against a history-based encoder model, and mid-frame reset.
module tb_conv_encoder_stream;

  logic             clk = 0;
  logic             rst;
  logic             i_start;
  logic [11:0]      i_frame_len;
  logic [3:0]       i_k;
  logic             i_code_rate;
  logic             i_tail_en;
  logic [2:0][8:0]  i_gen_poly;
  logic             i_valid;
  logic             i_data;
  logic             o_ready;
  logic             o_valid;
  logic             i_ready;
  logic [2:0]       o_sym;
  logic             o_last;
  logic             o_busy;
  logic             o_frame_done;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  conv_encoder_stream dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_frame_len  (i_frame_len),
    .i_k          (i_k),
    .i_code_rate  (i_code_rate),
    .i_tail_en    (i_tail_en),
    .i_gen_poly   (i_gen_poly),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_sym        (o_sym),
    .o_last       (o_last),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
  );

  typedef struct {
    int              k;
    bit              rate;
    bit              tail;
    int              len;
    logic [2:0][8:0] poly;
    logic [7:0]      data;
    int              rmode;
    int              nexp;
    logic [47:0]     exp;
  } vec_t;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic vec_t mkv(int k, bit rate, bit tail, int len,
                               logic [8:0] p0, logic [8:0] p1,
                               logic [8:0] p2, logic [7:0] data,
                               int rmode, int nexp, logic [47:0] exp);
    vec_t v;
    v.k = k; v.rate = rate; v.tail = tail; v.len = len;
    v.poly = {p2, p1, p0}; v.data = data; v.rmode = rmode;
    v.nexp = nexp; v.exp = exp;
    return v;
  endfunction

  // Symbol n sees input history x[n-j]; positions outside the data are 0.
  task automatic model(input int k, input bit rate, input bit tail,
                       input int len, input logic [2:0][8:0] poly,
                       input bit bits[$], output logic [2:0] q[$]);
    int keff, tot, idx;
    bit acc, b;
    q = {};
    keff = (k < 3 || k > 9) ? 9 : k;
    tot = len + (tail ? keff - 1 : 0);
    for (int n = 0; n < tot; n++) begin
      logic [2:0] s;
      s = '0;
      for (int i = 0; i < 3; i++) begin
        acc = 0;
        for (int j = 0; j < keff; j++) begin
          idx = n - j;
          b = (idx >= 0 && idx < len) ? bits[idx] : 1'b0;
          acc = acc ^ (b & poly[i][j]);
        end
        if (i == 2 && !rate) acc = 0;
        s[i] = acc;
      end
      q.push_back(s);
    end
  endtask

  task automatic run_frame(input int k, input bit rate, input bit tail,
                           input int len, input logic [2:0][8:0] poly,
                           input bit bits[$], input logic [2:0] exp[$],
                           input int rmode, input bit rnd);
    int bi, oi, cyc, lastcyc;
    logic [2:0] psym;
    logic plast;
    bit pstall, done;
    bi = 0; oi = 0; cyc = 0; lastcyc = -1;
    pstall = 0; done = 0; psym = '0; plast = 0;
    @(negedge clk);
    i_k = 4'(k); i_code_rate = rate; i_tail_en = tail;
    i_frame_len = 12'(len); i_gen_poly = poly;
    i_start = 1; i_valid = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      i_start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rnd) begin
        i_k = 4'($urandom); i_code_rate = 1'($urandom);
        i_tail_en = 1'($urandom); i_frame_len = 12'($urandom);
        i_gen_poly = 27'($urandom);
      end
      case (rmode)
        0:       i_ready = 1;
        1:       i_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: i_ready = ($urandom_range(0, 3) != 0);
      endcase
      i_valid = (bi < len) && (!rnd || $urandom_range(0, 3) != 0);
      i_data = (bi < len) ? bits[bi] : 1'($urandom);
      #1;
      if (cyc == 0) check(o_busy == 1, "busy", 32'(o_busy), 1);
      if (pstall)
        check(o_valid && o_sym == psym && o_last == plast, "hold",
              {o_valid, o_last, o_sym}, {1'b1, plast, psym});
      if (o_valid && !i_ready)
        check(o_ready == 0, "stall_rdy", 32'(o_ready), 0);
      if (bi == len)
        check(o_ready == 0, "tail_rdy", 32'(o_ready), 0);
      if (o_valid && i_ready) begin
        if (oi >= exp.size()) begin
          check(0, "extra_sym", 32'(oi), 32'(exp.size()));
        end else begin
          check(o_sym == exp[oi], "sym", 32'(o_sym), 32'(exp[oi]));
          check(o_last == (oi == exp.size() - 1), "last",
                32'(o_last), 32'(oi == exp.size() - 1));
        end
        oi++;
        lastcyc = cyc;
      end
      if (i_valid && o_ready) bi++;
      pstall = o_valid && !i_ready;
      psym = o_sym;
      plast = o_last;
      if (o_frame_done) begin
        check(oi == exp.size(), "sym_count", 32'(oi), 32'(exp.size()));
        check(bi == len, "bit_count", 32'(bi), 32'(len));
        check(o_valid == 0, "done_valid", 32'(o_valid), 0);
        if (exp.size() > 0)
          check(cyc == lastcyc + 1, "done_lat", 32'(cyc), 32'(lastcyc + 1));
        done = 1;
      end
      cyc++;
    end
    if (!done) check(0, "timeout", 32'(cyc), 0);
    i_start = 0;
    i_valid = 0;
    @(negedge clk);
    #1;
    check(o_frame_done == 0 && o_busy == 0, "done_pulse",
          {o_frame_done, o_busy}, 0);
  endtask

  vec_t tv[7];

  initial begin
    bit bits[$];
    logic [2:0] exq[$];
    logic [2:0][8:0] p;
    int k, len;
    bit rate, tail;

    tv[0] = mkv(3, 0, 1, 4, 9'h7, 9'h5, 9'h0, 8'b1101, 0, 6,
                {3'd3, 3'd2, 3'd2, 3'd0, 3'd1, 3'd3});
    tv[1] = mkv(3, 0, 1, 4, 9'h7, 9'h5, 9'h0, 8'b1101, 1, 6,
                {3'd3, 3'd2, 3'd2, 3'd0, 3'd1, 3'd3});
    tv[2] = mkv(3, 1, 0, 2, 9'h7, 9'h5, 9'h3, 8'b11, 0, 2,
                {3'd2, 3'd7});
    tv[3] = mkv(5, 0, 1, 0, 9'h1F, 9'h1F, 9'h1F, 8'b0, 0, 4, 48'd0);
    tv[4] = mkv(5, 0, 0, 0, 9'h1F, 9'h1F, 9'h1F, 8'b0, 0, 0, 48'd0);
    tv[5] = mkv(3, 0, 0, 2, 9'h7, 9'h5, 9'h3, 8'b11, 0, 2,
                {3'd2, 3'd3});
    tv[6] = mkv(2, 0, 1, 1, 9'h1FF, 9'h100, 9'h0, 8'b1, 2, 9,
                {3'd3, {8{3'd1}}});

    rst = 1; i_start = 0; i_frame_len = 0; i_k = 0; i_code_rate = 0;
    i_tail_en = 0; i_gen_poly = '0; i_valid = 0; i_data = 0; i_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    check({o_ready, o_valid, o_sym, o_last, o_busy, o_frame_done} == 0,
          "reset", {o_ready, o_valid, o_sym, o_last, o_busy, o_frame_done}, 0);
    @(negedge clk);
    rst = 0;

    for (int t = 0; t < 7; t++) begin
      bits = {};
      exq = {};
      for (int b = 0; b < tv[t].len; b++) bits.push_back(tv[t].data[b]);
      for (int s = 0; s < tv[t].nexp; s++) exq.push_back(tv[t].exp[3*s +: 3]);
      run_frame(tv[t].k, tv[t].rate, tv[t].tail, tv[t].len, tv[t].poly,
                bits, exq, tv[t].rmode, 0);
    end

    // Long K_MAX frame with random handshakes and start/config noise.
    bits = {};
    for (int b = 0; b < 3000; b++) bits.push_back(1'($urandom));
    p = 27'($urandom);
    rate = 1'($urandom);
    model(9, rate, 1, 3000, p, bits, exq);
    check(exq.size() == 3008, "model_len", 32'(exq.size()), 3008);
    run_frame(9, rate, 1, 3000, p, bits, exq, 2, 1);

    // Short random frames, including out-of-range K.
    for (int f = 0; f < 6; f++) begin
      k = $urandom_range(0, 15);
      len = $urandom_range(0, 40);
      rate = 1'($urandom);
      tail = 1'($urandom);
      p = 27'($urandom);
      bits = {};
      for (int b = 0; b < len; b++) bits.push_back(1'($urandom));
      model(k, rate, tail, len, p, bits, exq);
      run_frame(k, rate, tail, len, p, bits, exq, 2, 1);
    end

    // Reset mid-DATA, then a clean frame from zero state.
    @(negedge clk);
    i_k = 3; i_code_rate = 0; i_tail_en = 1; i_frame_len = 4;
    i_gen_poly = {9'h0, 9'h5, 9'h7}; i_start = 1;
    @(negedge clk);
    i_start = 0; i_valid = 1; i_data = 1; i_ready = 0;
    @(negedge clk);
    i_data = 1;
    #1;
    check(o_valid == 1 && o_busy == 1, "pre_rst", {o_valid, o_busy}, 3);
    #2;
    rst = 1;
    #1;
    check({o_ready, o_valid, o_sym, o_last, o_busy, o_frame_done} == 0,
          "async_rst", {o_ready, o_valid, o_sym, o_last, o_busy, o_frame_done}, 0);
    @(negedge clk);
    rst = 0;
    i_valid = 0;
    i_ready = 1;
    #1;
    check(o_valid == 0 && o_busy == 0, "post_rst", {o_valid, o_busy}, 0);
    bits = {};
    exq = {};
    for (int b = 0; b < 4; b++) bits.push_back(tv[0].data[b]);
    for (int s = 0; s < 6; s++) exq.push_back(tv[0].exp[3*s +: 3]);
    run_frame(3, 0, 1, 4, tv[0].poly, bits, exq, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
